// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a
// per-register pending scoreboard that drives the issue-stage hazard stalls.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*AW-1:0]   req_reg,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic                  Regwr,
    output logic [AW-1:0]         w_Reg,
    output logic [DW-1:0]         w_data,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_reg,
    output logic                  iss_stall,
    input  logic [AW-1:0]         rd_reg1,
    input  logic [AW-1:0]         rd_reg2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  pending_any
);

    localparam int RRW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREG = 2 ** AW;
    localparam logic [RRW:0] NREQ_W = (RRW + 1)'(N_REQ);

    logic [RRW-1:0]  rr_q, rr_d;
    logic            regwr_q, regwr_d;
    logic [AW-1:0]   w_reg_q, w_reg_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic            accept;
    logic [RRW:0]    gnt_idx;
    logic [RRW:0]    cand;
    logic [RRW:0]    rr_inc;
    logic [AW-1:0]   gnt_reg;
    logic [DW-1:0]   gnt_data;
    logic            iss_set;

    // Walk from the highest candidate down so the one nearest rr wins last.
    always_comb begin
        accept  = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (RRW + 1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req_valid[cand]) begin
                accept  = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst) begin
            accept = 1'b0;
        end
    end

    assign req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    assign gnt_reg   = req_reg[int'(gnt_idx) * AW +: AW];
    assign gnt_data  = req_data[int'(gnt_idx) * DW +: DW];

    always_comb begin
        rr_inc   = gnt_idx + (RRW + 1)'(1);
        rr_d     = rr_q;
        regwr_d  = 1'b0;
        w_reg_d  = w_reg_q;
        w_data_d = w_data_q;
        if (accept) begin
            rr_d     = (rr_inc == NREQ_W) ? '0 : rr_inc[RRW-1:0];
            regwr_d  = (gnt_reg != '0);
            w_reg_d  = gnt_reg;
            w_data_d = gnt_data;
        end
    end

    assign iss_stall = iss_valid & pending_q[iss_reg];
    assign iss_set   = iss_valid & ~iss_stall & (iss_reg != '0);

    // Set is applied after clear so a same-edge issue keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (regwr_q) begin
            pending_d[w_reg_q] = 1'b0;
        end
        if (iss_set) begin
            pending_d[iss_reg] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            regwr_q   <= 1'b0;
            w_reg_q   <= '0;
            w_data_q  <= '0;
            pending_q <= '0;
        end else begin
            rr_q      <= rr_d;
            regwr_q   <= regwr_d;
            w_reg_q   <= w_reg_d;
            w_data_q  <= w_data_d;
            pending_q <= pending_d;
        end
    end

    assign Regwr       = regwr_q;
    assign w_Reg       = w_reg_q;
    assign w_data      = w_data_q;
    assign busy1       = pending_q[rd_reg1];
    assign busy2       = pending_q[rd_reg2];
    assign pending_any = |pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write stage,
// register-0 drop, scoreboard hazards and asynchronous reset.
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_reg;
    logic [N*DW-1:0]   req_data;
    logic              Regwr;
    logic [AW-1:0]     w_Reg;
    logic [DW-1:0]     w_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_reg;
    logic              iss_stall;
    logic [AW-1:0]     rd_reg1;
    logic [AW-1:0]     rd_reg2;
    logic              busy1;
    logic              busy2;
    logic              pending_any;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] dat [0:2];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_reg    (req_reg),
        .req_data   (req_data),
        .Regwr      (Regwr),
        .w_Reg      (w_Reg),
        .w_data     (w_data),
        .iss_valid  (iss_valid),
        .iss_reg    (iss_reg),
        .iss_stall  (iss_stall),
        .rd_reg1    (rd_reg1),
        .rd_reg2    (rd_reg2),
        .busy1      (busy1),
        .busy2      (busy2),
        .pending_any(pending_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dat[0] = 32'hAAAA_0001;
        dat[1] = 32'hBBBB_0002;
        dat[2] = 32'hCCCC_0003;
        rst = 1'b1;
        req_valid = '0;
        req_reg = '0;
        req_data = '0;
        iss_valid = 1'b0;
        iss_reg = '0;
        rd_reg1 = '0;
        rd_reg2 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_regwr", 32'(Regwr), 32'd0);
        chk("rst_wreg", 32'(w_Reg), 32'd0);
        chk("rst_wdata", w_data, 32'd0);
        chk("rst_pending", 32'(pending_any), 32'd0);
        req_valid = 3'b111;
        req_reg[0*AW +: AW] = 5'd1;
        req_reg[1*AW +: AW] = 5'd2;
        req_reg[2*AW +: AW] = 5'd3;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = dat[i];
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;

        // Contention: seven grants rotate 0,1,2,0,1,2,0
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(3'b001 << (i % 3)));
            tick();
            chk($sformatf("rr_regwr_%0d", i), 32'(Regwr), 32'd1);
            chk($sformatf("rr_wreg_%0d", i), 32'(w_Reg), 32'((i % 3) + 1));
            chk($sformatf("rr_wdata_%0d", i), w_data, dat[i % 3]);
        end

        // Mid-cycle asynchronous reset with all requesters valid
        #2;
        rst = 1'b1;
        #1;
        chk("async_regwr", 32'(Regwr), 32'd0);
        chk("async_wreg", 32'(w_Reg), 32'd0);
        chk("async_wdata", w_data, 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b001);
        req_valid = '0;
        tick();
        chk("idle_regwr", 32'(Regwr), 32'd0);

        // Register 0 write is accepted then dropped (rr = 0)
        req_valid = 3'b010;
        req_reg[1*AW +: AW] = 5'd0;
        req_data[1*DW +: DW] = 32'hDEAD;
        #1;
        chk("r0_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        chk("r0_regwr", 32'(Regwr), 32'd0);
        chk("r0_wdata", w_data, 32'hDEAD);
        chk("r0_pending", 32'(pending_any), 32'd0);

        // RAW on reg 5 (rr = 2)
        iss_valid = 1'b1;
        iss_reg = 5'd5;
        #1;
        chk("raw_iss_stall", 32'(iss_stall), 32'd0);
        tick();
        iss_valid = 1'b0;
        rd_reg1 = 5'd5;
        rd_reg2 = 5'd0;
        #1;
        chk("raw_busy1_set", 32'(busy1), 32'd1);
        chk("raw_busy2_r0", 32'(busy2), 32'd0);
        chk("raw_pending", 32'(pending_any), 32'd1);
        req_valid = 3'b100;
        req_reg[2*AW +: AW] = 5'd5;
        req_data[2*DW +: DW] = 32'h55;
        #1;
        chk("raw_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        chk("raw_regwr", 32'(Regwr), 32'd1);
        chk("raw_wreg", 32'(w_Reg), 32'd5);
        chk("raw_wdata", w_data, 32'h55);
        chk("raw_busy1_t1", 32'(busy1), 32'd1);
        tick();
        chk("raw_busy1_t2", 32'(busy1), 32'd0);
        chk("raw_regwr_off", 32'(Regwr), 32'd0);

        // WAW on reg 7 (rr = 0)
        iss_valid = 1'b1;
        iss_reg = 5'd7;
        tick();
        rd_reg2 = 5'd7;
        #1;
        chk("waw_stall", 32'(iss_stall), 32'd1);
        req_valid = 3'b001;
        req_reg[0*AW +: AW] = 5'd7;
        req_data[0*DW +: DW] = 32'h77;
        #1;
        chk("waw_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        chk("waw_regwr", 32'(Regwr), 32'd1);
        chk("waw_wreg", 32'(w_Reg), 32'd7);
        chk("waw_commit_stall", 32'(iss_stall), 32'd1);
        tick();
        chk("waw_cleared_stall", 32'(iss_stall), 32'd0);
        chk("waw_cleared_busy2", 32'(busy2), 32'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("waw_reissued_busy2", 32'(busy2), 32'd1);

        // Same-edge set and clear on reg 8 (rr = 1)
        req_valid = 3'b010;
        req_reg[1*AW +: AW] = 5'd8;
        req_data[1*DW +: DW] = 32'h88;
        #1;
        chk("same_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        iss_valid = 1'b1;
        iss_reg = 5'd8;
        rd_reg1 = 5'd8;
        #1;
        chk("same_wreg", 32'(w_Reg), 32'd8);
        chk("same_stall", 32'(iss_stall), 32'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("same_set_wins", 32'(busy1), 32'd1);

        // Reset after accepting a reg 9 write, before it commits (rr = 2)
        iss_valid = 1'b1;
        iss_reg = 5'd9;
        tick();
        iss_valid = 1'b0;
        rd_reg1 = 5'd9;
        #1;
        chk("mid_busy_set", 32'(busy1), 32'd1);
        req_valid = 3'b100;
        req_reg[2*AW +: AW] = 5'd9;
        req_data[2*DW +: DW] = 32'h99;
        #1;
        chk("mid_ready", 32'(req_ready), 32'b100);
        @(posedge clk);
        rst = 1'b1;
        #1;
        req_valid = '0;
        chk("mid_regwr", 32'(Regwr), 32'd0);
        chk("mid_busy9", 32'(busy1), 32'd0);
        chk("mid_pending", 32'(pending_any), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_regwr_after", 32'(Regwr), 32'd0);
        chk("mid_pending_after", 32'(pending_any), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file. Shares the file's single write port (`Regwr`/`w_Reg`/`w_data`) among `N_REQ` producers (ALU, load unit, mul/div) using round-robin valid/ready arbitration and a registered write stage. It also keeps a per-register pending scoreboard so the issue stage can stall on RAW and WAW hazards. It sits between the execution units and the register file's write port; its busy outputs feed issue/decode.

## Interface
- `N_REQ`, default 3: number of write-back requesters, 2..8.
- `DW`, default 32: data width.
- `AW`, default 5: register address width; 2**AW registers.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset. Asynchronous and active-high.
- `req_valid` in N_REQ: requester i has a write pending.
- `req_ready` out N_REQ: requester i is accepted this cycle.
- `req_reg` in N_REQ*AW: destination register of requester i, in bits [i*AW +: AW].
- `req_data` in N_REQ*DW: write data of requester i, in bits [i*DW +: DW].
- `Regwr` out 1: register-file write enable (registered).
- `w_Reg` out AW: register-file write address (registered).
- `w_data` out DW: register-file write data (registered).
- `iss_valid` in 1: issue stage dispatching an instruction with a destination.
- `iss_reg` in AW: destination register of the issuing instruction.
- `iss_stall` out 1: issue must hold; the destination is already pending (combinational).
- `rd_reg1`, `rd_reg2` in AW: source registers being read by issue.
- `busy1`, `busy2` out 1: the corresponding source register is pending (combinational).
- `pending_any` out 1: OR of all pending bits.

## Operation
- **Arbitration, round-robin**
  - Pointer `rr` (width clog2(N_REQ)) names the highest-priority requester. Search runs `rr`, `rr`+1, … mod N_REQ.
  - The first requester with `req_valid` set gets `req_ready`=1; at most one ready bit is set per cycle.
  - `req_ready` is a combinational function of `req_valid` and `rr` only; it never depends on a ready from downstream. The write port never back-pressures.
  - On accepting requester g, `rr` <= (g+1) mod N_REQ. If nothing is accepted, `rr` holds.
- **Write stage**
  - On accept, the output register loads `Regwr`=(reg≠0), `w_Reg`=reg, `w_data`=data.
  - With no accept, `Regwr` <= 0; `w_Reg` and `w_data` hold their previous values.
  - Register 0 is hardwired zero. A write to it is accepted (ready=1) and then dropped (`Regwr`=0).
- **Scoreboard**
  - `pending[2**AW-1:0]`; bit 0 is always 0.
  - `iss_stall` = `iss_valid` & `pending[iss_reg]`.
  - Set: when `iss_valid` & !`iss_stall` & `iss_reg`≠0, `pending[iss_reg]` <= 1.
  - Clear: when `Regwr`=1 (output register active), `pending[w_Reg]` <= 0. This is the same edge that writes the register file, so a read in the following cycle sees the new value.
  - Set and clear of the same register on the same edge: set wins.
  - `busy1` = `pending[rd_reg1]`, `busy2` = `pending[rd_reg2]`. Both are 0 for register 0.
- Reset (async, any time, including mid-transfer) forces `rr`=0, `Regwr`=0, `w_Reg`=0, `w_data`=0, and all pending=0. An accepted but uncommitted write is lost. While `rst`=1, `req_ready` is all 0.

## Timing
- Accept cycle T (valid & ready high at edge T). The write-port outputs are valid during T+1, and the register file captures at edge T+1. Latency is 1 cycle.
- The pending clear takes effect after edge T+1; `busy` drops in cycle T+2.
- Back-to-back accepts every cycle are sustained: throughput is 1 write/cycle.
- With a single persistent requester, that requester is granted every cycle and `rr` cycles as (g+1) after each grant.
- `iss_stall`, `busy1`, `busy2` and `req_ready` are combinational, settling in the same cycle as their inputs. They are not registered.
- Requester contract: a requester holds `req_valid`, `req_reg` and `req_data` stable until it sees `req_ready`=1 at a clock edge.

## Test plan
- Reset then idle. Assert `rst` mid-cycle with `req_valid`=3'b111. Outputs go to 0 asynchronously, ready=0. After release, the first grant is `req_ready`=3'b001.
- Contention. Hold all three valid (regs 1/2/3, data A/B/C) for 6 cycles. Grants go 0,1,2,0,1,2. `Regwr`=1 each cycle from cycle 2, with `w_Reg` 1,2,3,1,2,3.
- Register 0. Requester 1 writes reg 0 with data 0xDEAD. `req_ready[1]`=1, `Regwr` stays 0, and no pending change occurs.
- Scoreboard RAW. Issue reg 5. `busy1`=1 for `rd_reg1`=5. Requester 2 writes reg 5 at cycle T. `Regwr`=1 with `w_Reg`=5 in T+1. `busy1`=0 in T+2.
- WAW and same-edge set. With reg 7 pending, issue reg 7: `iss_stall`=1 and it is not recorded. In the cycle where `Regwr` commits reg 7 and issue targets reg 7, the issue is stalled (still pending). On the next cycle, issue reg 7 is accepted and pending[7]=1.
- Mid-operation reset. Accept a write to reg 9 and assert `rst` before edge T+1. No `Regwr` pulse appears, and pending[9]=0.
